// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle for serial_magnitude_comparator.
// master: the producer/consumer around the comparator; slave: the comparator itself.
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int SC_W = $clog2(NDIG + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic             gt;
   logic             lt;
   logic [SC_W-1:0]  scan_cycles;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, eq, gt, lt, scan_cycles
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, eq, gt, lt, scan_cycles
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT bits per clock from the MSB
// downward and stops at the first differing digit. Signed compare is done by
// flipping the sign bit of both operands at load time, after which an unsigned
// digit scan gives the two's-complement ordering.
module serial_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_magnitude_comparator_if.slave bus
);
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int SC_W  = $clog2(NDIG + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(NDIG);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_r, a_nx_s;
   logic [WIDTH-1:0] b_r, b_nx_s;
   logic [IDX_W-1:0] idx_r, idx_nx_s;
   logic             out_valid_r, out_valid_nx_s;
   logic             eq_r, eq_nx_s;
   logic             gt_r, gt_nx_s;
   logic             lt_r, lt_nx_s;
   logic [SC_W-1:0]  scan_cycles_r, scan_cycles_nx_s;
   logic             in_ready_r;

   logic [31:0]      shamt_s;
   logic [WIDTH-1:0] a_shift_s;
   logic [WIDTH-1:0] b_shift_s;
   logic [DIGIT-1:0] a_dig_s;
   logic [DIGIT-1:0] b_dig_s;
   logic             dig_ne_s;
   logic             dig_gt_s;
   logic             last_s;

   // Select the current digit of each shadow operand and compare it.
   always_comb begin
      shamt_s   = 32'(idx_r) * 32'(DIGIT);
      a_shift_s = a_r << shamt_s;
      b_shift_s = b_r << shamt_s;
      a_dig_s   = a_shift_s[WIDTH-1 -: DIGIT];
      b_dig_s   = b_shift_s[WIDTH-1 -: DIGIT];
      dig_ne_s  = (a_dig_s != b_dig_s);
      dig_gt_s  = (a_dig_s > b_dig_s);
      last_s    = (idx_r == IDX_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) state_nx_s = SCAN;
            else              state_nx_s = IDLE;
         end
         SCAN: begin
            if (dig_ne_s || last_s) state_nx_s = DONE;
            else                    state_nx_s = SCAN;
         end
         DONE: begin
            if (bus.out_ready) state_nx_s = IDLE;
            else               state_nx_s = DONE;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Next values of the operand shadows, digit index and result registers.
   always_comb begin
      a_nx_s           = a_r;
      b_nx_s           = b_r;
      idx_nx_s         = idx_r;
      out_valid_nx_s   = out_valid_r;
      eq_nx_s          = eq_r;
      gt_nx_s          = gt_r;
      lt_nx_s          = lt_r;
      scan_cycles_nx_s = scan_cycles_r;
      case (state_r)
         IDLE: begin
            out_valid_nx_s = 1'b0;
            eq_nx_s        = 1'b0;
            gt_nx_s        = 1'b0;
            lt_nx_s        = 1'b0;
            idx_nx_s       = {IDX_W{1'b0}};
            if (bus.in_valid) begin
               a_nx_s = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
               b_nx_s = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
            end else begin
               a_nx_s = a_r;
               b_nx_s = b_r;
            end
         end
         SCAN: begin
            if (dig_ne_s) begin
               gt_nx_s          = dig_gt_s;
               lt_nx_s          = ~dig_gt_s;
               eq_nx_s          = 1'b0;
               scan_cycles_nx_s = SC_W'(idx_r) + SC_W'(1);
               out_valid_nx_s   = 1'b1;
            end else if (last_s) begin
               eq_nx_s          = 1'b1;
               gt_nx_s          = 1'b0;
               lt_nx_s          = 1'b0;
               scan_cycles_nx_s = SC_FULL;
               out_valid_nx_s   = 1'b1;
            end else begin
               idx_nx_s = idx_r + IDX_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_nx_s = 1'b0;
               eq_nx_s        = 1'b0;
               gt_nx_s        = 1'b0;
               lt_nx_s        = 1'b0;
            end else begin
               out_valid_nx_s = out_valid_r;
            end
         end
         default: begin
            out_valid_nx_s = 1'b0;
            eq_nx_s        = 1'b0;
            gt_nx_s        = 1'b0;
            lt_nx_s        = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; in_ready is registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r           <= {WIDTH{1'b0}};
         b_r           <= {WIDTH{1'b0}};
         idx_r         <= {IDX_W{1'b0}};
         out_valid_r   <= 1'b0;
         eq_r          <= 1'b0;
         gt_r          <= 1'b0;
         lt_r          <= 1'b0;
         scan_cycles_r <= {SC_W{1'b0}};
         in_ready_r    <= 1'b1;
      end else begin
         a_r           <= a_nx_s;
         b_r           <= b_nx_s;
         idx_r         <= idx_nx_s;
         out_valid_r   <= out_valid_nx_s;
         eq_r          <= eq_nx_s;
         gt_r          <= gt_nx_s;
         lt_r          <= lt_nx_s;
         scan_cycles_r <= scan_cycles_nx_s;
         in_ready_r    <= (state_nx_s == IDLE);
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.eq          = eq_r;
   assign bus.gt          = gt_r;
   assign bus.lt          = lt_r;
   assign bus.scan_cycles = scan_cycles_r;
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It scans from the MSB toward the LSB, DIGIT bits per clock, and stops as soon as the outcome is decided. It supports unsigned and two's-complement signed comparison, with valid/ready handshakes on both input and output. It is the sequential, wide-operand successor to the team's single-bit eq/gt/lt comparator, for datapaths where a full-width combinational compare would limit timing.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- DIGIT, 4, bits compared per clock; must be ≥ 1, and WIDTH % DIGIT must be 0.
- NDIG (local), WIDTH/DIGIT, number of digits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; equals 1 exactly when state is IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at the handshake.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- scan_cycles  output  clog2(NDIG+1)  number of SCAN edges used for this result (1..NDIG).

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - On an edge with in_valid=1, a and b are loaded into shadow registers and the digit index is set to 0 (the MSB digit). State goes to SCAN.
  - When signed_mode=1 at this edge, bit WIDTH-1 of both shadow copies is inverted. Unsigned ordering of the modified values then equals signed ordering of the originals.
- SCAN: each edge compares digit idx, i.e. bits [WIDTH-1-idx*DIGIT -: DIGIT] of both shadows.
  - Digits differ: register gt or lt from the digit-wise unsigned compare, load scan_cycles=idx+1, set out_valid=1, go to DONE.
  - Digits equal and idx = NDIG-1: register eq=1, load scan_cycles=NDIG, set out_valid=1, go to DONE.
  - Otherwise: idx increments and state stays in SCAN.
- DONE:
  - out_valid, eq, gt, lt and scan_cycles are held stable until an edge with out_ready=1.
  - At that edge, out_valid, eq, gt and lt clear to 0 and state goes to IDLE. scan_cycles keeps its value.
- Whenever out_valid=1, exactly one of eq, gt, lt is 1. All three are 0 whenever out_valid=0.
- in_valid is ignored outside IDLE, and a/b/signed_mode are not sampled then. Operand changes after the handshake do not affect the result.
- No back-to-back acceptance: at least one IDLE cycle separates transactions.
- Digit index width is max(1, clog2(NDIG)). It never exceeds NDIG-1, so there is no wrap.

## Timing
- Reset (asynchronous assertion, any state, including mid-SCAN or DONE with out_ready=0):
  - Immediately: state=IDLE, out_valid=0, eq=gt=lt=0, scan_cycles=0, index=0, in_ready=1.
  - The transaction in flight is discarded.
  - Deassertion is synchronous to clk externally. The first handshake can occur on the first edge after deassertion.
- Latency: let handshake edge = E0 and j = index of the first differing digit (j = NDIG-1 for equal operands).
  - out_valid rises after edge E0+j+1.
  - Minimum latency is 1 edge; maximum is NDIG edges.
- in_ready drops after E0 and returns after the edge at which out_valid && out_ready.
- out_ready may be held high permanently. The result is then valid for exactly one cycle.
- out_ready while out_valid=0 has no effect.

## Test plan
All cases use WIDTH=16, DIGIT=4.
1. Equal operands: unsigned a=0x1234, b=0x1234 → out_valid 4 edges after handshake; eq=1, gt=lt=0, scan_cycles=4.
2. MSB digit differs, both modes:
   - a=0x8000, b=0x7FFF, signed_mode=0 → gt=1 after 1 edge, scan_cycles=1.
   - Same operands, signed_mode=1 → lt=1 after 1 edge.
3. Early termination and signed negatives:
   - a=0x12F4, b=0x12E4 unsigned → gt=1 after 3 edges, scan_cycles=3.
   - a=0xFFFF, b=0xFFFE signed → gt=1 after 4 edges.
4. Backpressure: with out_ready=0 for 5 cycles, out_valid, the flags and scan_cycles stay constant and in_ready=0. A new in_valid pulse (a=0, b=1) is ignored. After out_ready=1 for one edge → out_valid=0, in_ready=1.
5. Reset mid-scan: start a=0x0001, b=0x0002; pull rst_n low after 2 SCAN edges → out_valid, eq, gt, lt and scan_cycles are 0 and in_ready=1 without a clock edge. A following transaction a=0x0003, b=0x0002 → gt=1 after 4 edges.
6. Streaming with out_ready tied high: 50 random operand/mode pairs → each result matches a reference compare, and scan_cycles = first differing digit index + 1.
